// File: rtl/vga_scandoubler.sv
// Line doubler: stores each 15 kHz input line in one of two banks and replays
// the previous line twice at twice the pixel rate. Bypass forwards native RGB/csync.
module vga_scandoubler #(
  parameter int HTOTAL    = 448,
  parameter int BLANK_BEG = 320,
  parameter int BLANK_END = 416,
  parameter int HS_BEG    = 344,
  parameter int HS_END    = 376,
  parameter int VS_BEG    = 248,
  parameter int VS_END    = 251
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic [8:0] hc_in,
  input  logic [8:0] vc_in,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [2:0] b_in,
  input  logic       csync_in,
  input  logic       scandbl_en,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       vga_hsync_n,
  output logic       vga_vsync_n
);

  localparam logic [8:0] HT      = 9'(HTOTAL);
  localparam logic [8:0] HT_LAST = 9'(HTOTAL - 1);
  localparam logic [8:0] BL_BEG  = 9'(BLANK_BEG);
  localparam logic [8:0] BL_END  = 9'(BLANK_END);
  localparam logic [8:0] HSB     = 9'(HS_BEG);
  localparam logic [8:0] HSE     = 9'(HS_END);
  localparam logic [8:0] VSB     = 9'(VS_BEG);
  localparam logic [8:0] VSE     = 9'(VS_END);

  // bank select is the address MSB, so each bank spans 512 words
  logic [8:0] mem [0:1023];
  logic [8:0] rd_data;

  logic       ph;
  logic       out_ce;
  logic       line_start;
  logic       rdbank;
  logic       valid;
  logic       seen_start;
  logic [8:0] ohc;
  logic [8:0] col_q;
  logic [8:0] vc_q;

  // ph == 0 marks an output-pixel cycle; a line start clears it so the
  // very next clk28 reads column 0
  assign out_ce     = ~ph;
  assign line_start = pix_ce && (hc_in == 9'd0);

  always_ff @(posedge clk28) begin
    if (pix_ce && (hc_in < HT))
      mem[{vc_in[0], hc_in}] <= {r_in, g_in, b_in};
    if (out_ce && !line_start)
      rd_data <= mem[{rdbank, ohc}];
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      ph         <= 1'b0;
      ohc        <= 9'd0;
      rdbank     <= 1'b0;
      valid      <= 1'b0;
      seen_start <= 1'b0;
      col_q      <= 9'd0;
      vc_q       <= 9'd0;
    end else begin
      if (pix_ce)
        vc_q <= vc_in;
      if (line_start) begin
        ph         <= 1'b0;
        ohc        <= 9'd0;
        rdbank     <= ~vc_in[0];
        seen_start <= 1'b1;
        if (seen_start)
          valid <= 1'b1;
      end else begin
        ph <= ~ph;
        if (out_ce) begin
          col_q <= ohc;
          // wrapping without a new line start replays the same bank
          if (ohc == HT_LAST)
            ohc <= 9'd0;
          else
            ohc <= ohc + 9'd1;
        end
      end
    end
  end

  // col_q and rd_data move together, so sync and blanking stay aligned with RGB
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 9'd0;
      vga_hsync_n           <= 1'b1;
      vga_vsync_n           <= 1'b1;
    end else if (!scandbl_en) begin
      if (pix_ce) begin
        {vga_r, vga_g, vga_b} <= {r_in, g_in, b_in};
        vga_hsync_n           <= csync_in;
      end
      vga_vsync_n <= 1'b1;
    end else begin
      if (!valid || ((col_q >= BL_BEG) && (col_q < BL_END)))
        {vga_r, vga_g, vga_b} <= 9'd0;
      else
        {vga_r, vga_g, vga_b} <= rd_data;
      vga_hsync_n <= !((col_q >= HSB) && (col_q < HSE));
      vga_vsync_n <= !((vc_q >= VSB) && (vc_q <= VSE));
    end
  end

endmodule

// File: tb/tb_vga_scandoubler.sv
// Bench for vga_scandoubler: a line-buffer model predicts every doubled output
// pixel at line start; a negedge checker pops and compares them.
module tb_vga_scandoubler;

  logic       clk28, rst, pix_ce, csync_in, scandbl_en;
  logic [8:0] hc_in, vc_in;
  logic [2:0] r_in, g_in, b_in;
  logic [2:0] vga_r, vga_g, vga_b;
  logic       vga_hsync_n, vga_vsync_n;

  vga_scandoubler dut (
    .clk28(clk28), .rst(rst), .pix_ce(pix_ce), .hc_in(hc_in), .vc_in(vc_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .csync_in(csync_in),
    .scandbl_en(scandbl_en), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync_n(vga_hsync_n), .vga_vsync_n(vga_vsync_n)
  );

  localparam int K_RED = 0, K_RAMP = 1, K_RAND = 2, K_ZERO = 3;

  typedef struct {
    int         cyc;
    int         col;
    logic [8:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t       sb[$];
  exp_t       chk_e;
  logic [8:0] model [2][448];
  int         cyc = 0;
  int         starts = 0;
  int         hs_low = 0;
  int         total = 0;
  int         bad = 0;

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  always @(posedge clk28) cyc <= cyc + 1;

  always @(negedge clk28) if (!vga_hsync_n) hs_low <= hs_low + 1;

  always @(negedge clk28) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) sb.delete(0);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      chk_e = sb.pop_front();
      total++;
      if ({vga_r, vga_g, vga_b} !== chk_e.rgb || vga_hsync_n !== chk_e.hs ||
          vga_vsync_n !== chk_e.vs) begin
        bad++;
        $display("FAIL sb_pixel cyc=%0d col=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                 cyc, chk_e.col, {vga_r, vga_g, vga_b}, vga_hsync_n, vga_vsync_n,
                 chk_e.rgb, chk_e.hs, chk_e.vs);
      end
    end
  end

  function automatic logic [8:0] pat(input int kind, input int hc);
    logic [8:0] v;
    case (kind)
      K_RED:   v = 9'h1C0;
      K_RAMP:  v = hc[8:0];
      K_RAND:  v = 9'($urandom_range(1, 511));
      default: v = 9'd0;
    endcase
    return v;
  endfunction

  // called just after the edge that sampled hc_in==0
  task automatic model_line_start(input int vc);
    exp_t e;
    logic v;
    logic rb;
    while (sb.size() > 0 && sb[sb.size()-1].cyc >= cyc) sb.delete(sb.size()-1);
    v  = (starts > 0);
    rb = ~vc[0];
    starts++;
    if (scandbl_en) begin
      for (int h = 0; h < 3; h++) begin
        for (int n = 0; n < 448; n++) begin
          e.col = n;
          e.rgb = (!v || (n >= 320 && n < 416)) ? 9'd0 : model[rb][n];
          e.hs  = !(n >= 344 && n < 376);
          e.vs  = !(vc >= 248 && vc <= 251);
          e.cyc = cyc + 2 + 2*n + 896*h;
          sb.push_back(e);
          e.cyc = e.cyc + 1;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic drive_pixel(input int vc, input int hc, input logic [8:0] rgb, input logic cs);
    vc_in = vc[8:0];
    hc_in = hc[8:0];
    {r_in, g_in, b_in} = rgb;
    csync_in = cs;
    pix_ce = 1'b1;
    @(posedge clk28); #1;
    pix_ce = 1'b0;
    if (hc < 448) model[vc[0]][hc] = rgb;
    if (hc == 0) model_line_start(vc);
    repeat (3) @(posedge clk28);
    #1;
  endtask

  task automatic run_line(input int vc, input int len, input int kind);
    for (int h = 0; h < len; h++) drive_pixel(vc, h, pat(kind, h), 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_ce = 1'b0; scandbl_en = 1'b1; csync_in = 1'b1;
    hc_in = 9'd1; vc_in = 9'd0; r_in = 3'd0; g_in = 3'd0; b_in = 3'd0;
    repeat (4) @(posedge clk28);
    #1;
    total++;
    if ({vga_r, vga_g, vga_b} !== 9'd0) begin
      bad++; $display("FAIL reset_rgb got=%h want=000", {vga_r, vga_g, vga_b});
    end
    total++;
    if (vga_hsync_n !== 1'b1) begin
      bad++; $display("FAIL reset_hsync got=%b want=1", vga_hsync_n);
    end
    total++;
    if (vga_vsync_n !== 1'b1) begin
      bad++; $display("FAIL reset_vsync got=%b want=1", vga_vsync_n);
    end
    rst = 1'b0;
    starts = 0;
    @(posedge clk28); #1;
  endtask

  task automatic test_blank();
    run_line(0, 448, K_RED);
    run_line(1, 448, K_ZERO);
  endtask

  task automatic test_ramp();
    run_line(10, 448, K_RAMP);
    run_line(11, 448, K_ZERO);
  endtask

  task automatic test_hsync();
    hs_low = 0;
    run_line(12, 448, K_RAND);
    total++;
    if (hs_low !== 128) begin
      bad++; $display("FAIL hsync_low_cycles got=%0d want=128", hs_low);
    end
  endtask

  task automatic test_back_to_back();
    for (int v = 13; v <= 15; v++) run_line(v, 448, K_RAND);
  endtask

  task automatic test_short_line();
    run_line(16, 300, K_RAND);
    run_line(17, 448, K_RAND);
    run_line(18, 448, K_RAND);
  endtask

  task automatic test_long_line();
    run_line(19, 500, K_RAND);
    run_line(20, 448, K_RAND);
  endtask

  task automatic test_vsync();
    for (int v = 247; v <= 252; v++) run_line(v, 448, K_RAND);
  endtask

  task automatic test_bypass();
    sb.delete();
    scandbl_en = 1'b0;
    vc_in = 9'd253; hc_in = 9'd5;
    r_in = 3'd5; g_in = 3'd2; b_in = 3'd3; csync_in = 1'b0;
    pix_ce = 1'b1;
    @(posedge clk28); #1;
    pix_ce = 1'b0;
    model[1][5] = 9'b101_010_011;
    total++;
    if ({vga_r, vga_g, vga_b} !== 9'b101_010_011) begin
      bad++; $display("FAIL bypass_rgb got=%h want=%h", {vga_r, vga_g, vga_b}, 9'b101_010_011);
    end
    total++;
    if (vga_hsync_n !== 1'b0) begin
      bad++; $display("FAIL bypass_csync got=%b want=0", vga_hsync_n);
    end
    total++;
    if (vga_vsync_n !== 1'b1) begin
      bad++; $display("FAIL bypass_vsync got=%b want=1", vga_vsync_n);
    end
    r_in = 3'd1; csync_in = 1'b1;
    repeat (2) @(posedge clk28);
    #1;
    total++;
    if (vga_r !== 3'd5 || vga_hsync_n !== 1'b0) begin
      bad++; $display("FAIL bypass_hold got r=%0d hs=%b want r=5 hs=0", vga_r, vga_hsync_n);
    end
    drive_pixel(253, 6, 9'b010_111_001, 1'b1);
    total++;
    if ({vga_r, vga_g, vga_b} !== 9'b010_111_001 || vga_hsync_n !== 1'b1) begin
      bad++; $display("FAIL bypass_second got rgb=%h hs=%b want rgb=%h hs=1",
                      {vga_r, vga_g, vga_b}, vga_hsync_n, 9'b010_111_001);
    end
    scandbl_en = 1'b1;
  endtask

  task automatic test_async_reset();
    run_line(254, 448, K_RAND);
    run_line(255, 50, K_RAND);
    #2;
    rst = 1'b1;
    sb.delete();
    starts = 0;
    #1;
    total++;
    if ({vga_r, vga_g, vga_b} !== 9'd0 || vga_hsync_n !== 1'b1 || vga_vsync_n !== 1'b1) begin
      bad++; $display("FAIL async_reset got rgb=%h hs=%b vs=%b want rgb=000 hs=1 vs=1",
                      {vga_r, vga_g, vga_b}, vga_hsync_n, vga_vsync_n);
    end
    repeat (3) @(posedge clk28);
    #1;
    total++;
    if ({vga_r, vga_g, vga_b} !== 9'd0 || vga_hsync_n !== 1'b1) begin
      bad++; $display("FAIL reset_held got rgb=%h hs=%b want rgb=000 hs=1",
                      {vga_r, vga_g, vga_b}, vga_hsync_n);
    end
    rst = 1'b0;
    @(posedge clk28); #1;
    run_line(256, 448, K_RAND);
    run_line(257, 448, K_RAND);
  endtask

  initial begin
    test_reset();
    test_blank();
    test_ramp();
    test_hsync();
    test_back_to_back();
    test_short_line();
    test_long_line();
    test_vsync();
    test_bypass();
    test_async_reset();
    sb.delete();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
